// File: rtl/tiny_control_unit.sv
// tiny_control_unit: multi-cycle fetch/decode/execute sequencer for TinyCPU.
// Owns PC and IR; drives per-register enables, bus-source and ALU-op selects.
// All outputs are combinational from state and IR so Clr takes effect at once.
module tiny_control_unit #(
   parameter int unsigned            PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
   input  logic                Clock,
   input  logic                Clr,
   input  logic                Run,
   input  logic [7:0]          Instr,
   output logic [PC_WIDTH-1:0] Addr,
   output logic [3:0]          RegEn,
   output logic [1:0]          RxSel,
   output logic [1:0]          RySel,
   output logic [1:0]          BusSel,
   output logic [1:0]          AluOp,
   output logic                Busy,
   output logic                Halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_IMM,
      S_EXEC,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_LDI  = 3'b001,
      OP_MOV  = 3'b010,
      OP_ADD  = 3'b011,
      OP_SUB  = 3'b100,
      OP_XOR  = 3'b101,
      OP_RSV  = 3'b110,
      OP_HALT = 3'b111
   } opcode_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [7:0]          ir_q, ir_d;
   opcode_t             op;
   logic [3:0]          rx_onehot;
   logic                unused_ir0;

   assign op         = opcode_t'(ir_q[7:5]);
   assign rx_onehot  = 4'b0001 << ir_q[4:3];
   assign unused_ir0 = ir_q[0];

   // State, PC and IR registers; Clr clears them asynchronously.
   always_ff @(posedge Clock or posedge Clr) begin
      if (Clr) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state, PC/IR update and datapath control decode.
   // The END pseudo-state is folded into the last cycle of each instruction:
   // that cycle samples Run and branches straight to FETCH or IDLE.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      RegEn   = '0;
      BusSel  = 2'b00;
      AluOp   = 2'b00;
      unique case (state_q)
         S_IDLE: begin
            if (Run) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_d    = Instr;
            pc_d    = pc_q + PC_WIDTH'(1);
            state_d = S_DECODE;
         end
         S_DECODE: begin
            unique case (op)
               OP_HALT:                        state_d = S_HALT;
               OP_LDI:                         state_d = S_IMM;
               OP_MOV, OP_ADD, OP_SUB, OP_XOR: state_d = S_EXEC;
               default:                        state_d = Run ? S_FETCH : S_IDLE;
            endcase
         end
         S_IMM: begin
            RegEn   = rx_onehot;
            BusSel  = 2'b01;
            pc_d    = pc_q + PC_WIDTH'(1);
            state_d = Run ? S_FETCH : S_IDLE;
         end
         S_EXEC: begin
            RegEn = rx_onehot;
            unique case (op)
               OP_MOV: begin
                  BusSel = 2'b10;
                  AluOp  = 2'b11;
               end
               OP_SUB:  AluOp = 2'b01;
               OP_XOR:  AluOp = 2'b10;
               default: AluOp = 2'b00;
            endcase
            state_d = Run ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign Addr   = pc_q;
   assign RxSel  = ir_q[4:3];
   assign RySel  = ir_q[2:1];
   assign Busy   = (state_q != S_IDLE) && (state_q != S_HALT);
   assign Halted = (state_q == S_HALT);

endmodule

// File: tb/tb_tiny_control_unit.sv
// Testbench for tiny_control_unit: instruction-level reference model plus
// directed programs with hand-computed checkpoints.
module tb_tiny_control_unit;

   logic       Clock = 1'b0;
   logic       Clr   = 1'b0;
   logic       Run   = 1'b0;
   logic       Run_w = 1'b0;
   logic [7:0] mem   [256];
   logic [7:0] mem_w [256];

   logic [7:0] Instr, Addr, Instr_w, Addr_w;
   logic [3:0] RegEn, RegEn_w;
   logic [1:0] RxSel, RySel, BusSel, AluOp;
   logic [1:0] RxSel_w, RySel_w, BusSel_w, AluOp_w;
   logic       Busy, Halted, Busy_w, Halted_w;

   int checks   = 0;
   int failures = 0;

   assign Instr   = mem[Addr];
   assign Instr_w = mem_w[Addr_w];

   tiny_control_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
      .Clock(Clock), .Clr(Clr), .Run(Run), .Instr(Instr), .Addr(Addr),
      .RegEn(RegEn), .RxSel(RxSel), .RySel(RySel), .BusSel(BusSel),
      .AluOp(AluOp), .Busy(Busy), .Halted(Halted)
   );

   tiny_control_unit #(.PC_WIDTH(8), .RESET_PC(8'hFF)) dut_w (
      .Clock(Clock), .Clr(Clr), .Run(Run_w), .Instr(Instr_w), .Addr(Addr_w),
      .RegEn(RegEn_w), .RxSel(RxSel_w), .RySel(RySel_w), .BusSel(BusSel_w),
      .AluOp(AluOp_w), .Busy(Busy_w), .Halted(Halted_w)
   );

   always #5 Clock = ~Clock;

   function automatic void chk(string name, int unsigned act, int unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   // ---------------- reference model (instruction level) ----------------
   // Each started instruction expands into its list of expected bus cycles.
   typedef struct packed {
      logic [7:0] addr;
      logic [3:0] regen;
      logic [1:0] rx;
      logic [1:0] ry;
      logic [1:0] bus;
      logic [1:0] alu;
      logic       last;
      logic       halt;
   } cyc_t;

   cyc_t       q[$];
   logic [7:0] m_pc   = 8'h00;
   logic [7:0] m_ir   = 8'h00;
   bit         m_halt = 1'b0;

   function automatic cyc_t mk(logic [7:0] a, logic [7:0] ir, logic [3:0] en,
                               logic [1:0] bus, logic [1:0] alu, bit last, bit halt);
      cyc_t c;
      c.addr = a; c.regen = en; c.rx = ir[4:3]; c.ry = ir[2:1];
      c.bus = bus; c.alu = alu; c.last = last; c.halt = halt;
      return c;
   endfunction

   task automatic start_instr();
      logic [7:0] b;
      logic [2:0] op;
      logic [3:0] en;
      b  = mem[m_pc];
      op = b[7:5];
      en = 4'b0001 << b[4:3];
      q.push_back(mk(m_pc, m_ir, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0));
      m_ir = b;
      m_pc = m_pc + 8'd1;
      case (op)
         3'd0, 3'd6: q.push_back(mk(m_pc, b, 4'h0, 2'b00, 2'b00, 1'b1, 1'b0));
         3'd7:       q.push_back(mk(m_pc, b, 4'h0, 2'b00, 2'b00, 1'b1, 1'b1));
         3'd1: begin
            q.push_back(mk(m_pc, b, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0));
            q.push_back(mk(m_pc, b, en,   2'b01, 2'b00, 1'b1, 1'b0));
            m_pc = m_pc + 8'd1;
         end
         default: begin
            q.push_back(mk(m_pc, b, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0));
            if (op == 3'd2)
               q.push_back(mk(m_pc, b, en, 2'b10, 2'b11, 1'b1, 1'b0));
            else
               q.push_back(mk(m_pc, b, en, 2'b00, 2'(op - 3'd3), 1'b1, 1'b0));
         end
      endcase
   endtask

   always @(posedge Clock or posedge Clr) begin
      cyc_t h;
      if (Clr) begin
         q.delete();
         m_pc   = 8'h00;
         m_ir   = 8'h00;
         m_halt = 1'b0;
      end else if (!m_halt) begin
         if (q.size() == 0) begin
            if (Run) start_instr();
         end else begin
            h = q.pop_front();
            if (h.last) begin
               if (h.halt)   m_halt = 1'b1;
               else if (Run) start_instr();
            end
         end
      end
   end

   // Every-cycle comparison of the main DUT against the model.
   always @(negedge Clock) begin
      cyc_t e;
      logic busy_e;
      if (q.size() != 0) begin
         e      = q[0];
         busy_e = 1'b1;
      end else begin
         e      = mk(m_pc, m_ir, 4'h0, 2'b00, 2'b00, 1'b0, 1'b0);
         busy_e = 1'b0;
      end
      chk("model_outputs",
          32'({Addr, RegEn, RxSel, RySel, BusSel, AluOp, Busy, Halted}),
          32'({e.addr, e.regen, e.rx, e.ry, e.bus, e.alu, busy_e, m_halt}));
      chk("regen_onehot", 32'($countones(RegEn) > 1), 32'd0);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(negedge Clock);
      #2;
   endtask

   task automatic do_clr();
      Clr = 1'b1;
      tick();
      tick();
      Clr = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]   = 8'h00;
         mem_w[i] = 8'h00;
      end
      #1;
      do_clr();

      // Idle with Run low
      repeat (10) tick();
      chk("idle_addr", Addr, 8'h00);
      chk("idle_regen", RegEn, 4'h0);
      chk("idle_busy", Busy, 1'b0);
      chk("wrap_reset_addr", Addr_w, 8'hFF);

      // LDI R1, 5A
      mem[0] = 8'h28; mem[1] = 8'h5A;
      Run = 1'b1;
      tick(); chk("ldi_fetch_addr", Addr, 8'h00);
      tick(); chk("ldi_decode_rx", RxSel, 2'd1);
      tick();
      chk("ldi_regen", RegEn, 4'b0010);
      chk("ldi_bussel", BusSel, 2'b01);
      chk("ldi_addr", Addr, 8'h01);
      chk("ldi_instr", Instr, 8'h5A);
      Run = 1'b0;
      tick(); chk("ldi_pc_after", Addr, 8'h02);

      // ADD R1,R1 then SUB R3,R2
      do_clr();
      mem[0] = 8'h6A; mem[1] = 8'h9C;
      Run = 1'b1;
      tick(); tick(); tick();
      chk("add_regen", RegEn, 4'b0010);
      chk("add_bussel", BusSel, 2'b00);
      chk("add_aluop", AluOp, 2'b00);
      chk("add_rx", RxSel, 2'd1);
      chk("add_ry", RySel, 2'd1);
      tick(); tick(); tick();
      chk("sub_regen", RegEn, 4'b1000);
      chk("sub_aluop", AluOp, 2'b01);
      chk("sub_ry", RySel, 2'd2);
      Run = 1'b0;
      tick(); chk("sub_idle_busy", Busy, 1'b0);

      // NOP, reserved, HALT
      do_clr();
      mem[0] = 8'h00; mem[1] = 8'hC0; mem[2] = 8'hE0;
      Run = 1'b1;
      tick(); tick(); tick();
      chk("nop_next_fetch", Addr, 8'h01);
      tick(); tick();
      chk("rsv_next_fetch", Addr, 8'h02);
      tick(); tick();
      chk("halt_halted", Halted, 1'b1);
      chk("halt_busy", Busy, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("halt_pc_held", Addr, 8'h03);
      end
      Run = 1'b0;

      // Clr mid-EXEC of MOV R0,R3
      do_clr();
      mem[0] = 8'h46;
      Run = 1'b1;
      tick(); tick(); tick();
      chk("mov_regen", RegEn, 4'b0001);
      chk("mov_bussel", BusSel, 2'b10);
      chk("mov_aluop", AluOp, 2'b11);
      #1 Clr = 1'b1;
      #1;
      chk("async_clr_regen", RegEn, 4'h0);
      chk("async_clr_addr", Addr, 8'h00);
      chk("async_clr_busy", Busy, 1'b0);
      Run = 1'b0;
      tick();
      Clr = 1'b0;

      // Pause at END, then resume from the retained PC
      mem[0] = 8'h00; mem[1] = 8'h6A;
      Run = 1'b1;
      tick();
      Run = 1'b0;
      tick();
      repeat (3) tick();
      chk("pause_addr", Addr, 8'h01);
      chk("pause_busy", Busy, 1'b0);
      Run = 1'b1;
      tick(); chk("resume_fetch_addr", Addr, 8'h01);
      tick(); tick();
      chk("resume_exec_regen", RegEn, 4'b0010);
      Run = 1'b0;
      tick(); chk("resume_pc_after", Addr, 8'h02);

      // PC wrap on the RESET_PC=FF instance: LDI at FF, immediate at 00
      do_clr();
      mem_w[8'hFF] = 8'h28; mem_w[8'h00] = 8'h77;
      chk("wrap_addr_reset", Addr_w, 8'hFF);
      Run_w = 1'b1;
      tick(); chk("wrap_fetch_addr", Addr_w, 8'hFF);
      tick(); chk("wrap_after_fetch", Addr_w, 8'h00);
      Run_w = 1'b0;
      tick();
      chk("wrap_imm_regen", RegEn_w, 4'b0010);
      chk("wrap_imm_bussel", BusSel_w, 2'b01);
      chk("wrap_imm_data", Instr_w, 8'h77);
      tick();
      chk("wrap_pc_after", Addr_w, 8'h01);
      chk("wrap_idle_busy", Busy_w, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

endmodule
